axis_packet_buffer: RTL and testbench
=====================================

// Module: axis_packet_buffer
// PURPOSE
//  Single-clock AXI-Stream buffer memory: stores beats from the s01 slave port in a
//  2**ADDR_WIDTH-deep circular RAM and replays them in order on the m01 master port.
//  Full valid/ready backpressure on both sides. Optional store-and-forward packet mode
//  with oversized-packet drop. Sits between stream producers and consumers in the lab datapath.
// PARAMETERS
//  DATA_WIDTH   32  tdata width in bits; multiple of 8; tstrb width = DATA_WIDTH/8
//  ADDR_WIDTH   10  RAM address bits; DEPTH = 2**ADDR_WIDTH words
//  PACKET_MODE  0   0 = cut-through (word streaming); 1 = store-and-forward on tlast
// PORTS
//  axis_aclk          in   1             single clock, all logic on rising edge
//  axis_areset        in   1             synchronous reset, active-high
//  s01_axis_tdata     in   DATA_WIDTH    write data
//  s01_axis_tstrb     in   DATA_WIDTH/8  byte strobes, stored with data
//  s01_axis_tvalid    in   1             write beat valid
//  s01_axis_tlast     in   1             last beat of packet, stored with data
//  s01_axis_tready    out  1             buffer can accept a beat
//  m01_axis_tdata     out  DATA_WIDTH    read data
//  m01_axis_tstrb     out  DATA_WIDTH/8  read strobes
//  m01_axis_tvalid    out  1             read beat valid
//  m01_axis_tlast     out  1             read last
//  m01_axis_tready    in   1             consumer ready
//  occupancy          out  ADDR_WIDTH+1  words held (RAM + output register), 0..DEPTH
//  pkt_count          out  ADDR_WIDTH+1  complete packets held (tlast beats stored, not yet read)
//  drop_pulse         out  1             1-cycle pulse when an oversized packet is discarded
// BEHAVIOUR
//  - Reset (axis_areset=1 at edge): all pointers/counters 0, s01_axis_tready=0, m01_axis_tvalid=0,
//    m01_axis_tdata/tstrb/tlast=0, occupancy=0, pkt_count=0, drop_pulse=0, write FSM=ACCEPT.
//    Reset mid-packet discards all contents including partial packets. RAM contents not cleared.
//  - Transfer occurs when valid & ready are both 1 at a rising edge.
//  - s01_axis_tready = !axis_areset & (occupancy < DEPTH) in ACCEPT; forced 1 in DISCARD.
//    Full is judged on current occupancy: a write at full is refused even if a read completes
//    in the same cycle. Simultaneous accepted read+write: occupancy unchanged.
//  - m01 side: first-word-fall-through output register. Once m01_axis_tvalid=1, tdata/tstrb/tlast
//    hold stable until accepted. Back-to-back reads at 1 word/cycle while m01_axis_tready=1.
//  - Latency, PACKET_MODE=0: beat accepted at edge k is on m01 (tvalid=1) after edge k+2 if empty.
//  - PACKET_MODE=1: a beat is eligible for read only once its packet's tlast beat is committed;
//    first beat of a packet appears after edge t+2, t = edge accepting tlast. Committed packets
//    then stream at full rate. pkt_count +1 on tlast write commit, -1 on tlast read.
//  - Pointers are ADDR_WIDTH bits, wrap modulo DEPTH; occupancy arithmetic is ADDR_WIDTH+1 bits.
//  - Write FSM (PACKET_MODE=1 only; mode 0 stays in ACCEPT):
//    ACCEPT: store beats at wr_ptr; on tlast commit wr_ptr to pkt_start. If occupancy==DEPTH and
//      pkt_count==0 (packet cannot fit) -> rewind wr_ptr to pkt_start, release its words,
//      pulse drop_pulse, go DISCARD.
//    DISCARD: accept and drop beats; on accepted tlast -> ACCEPT.
//  - A beat with tlast in ACCEPT when the packet already fills memory is not split: drop rule applies.
// TESTING
//  1 Reset: hold axis_areset 3 cycles with s01 tvalid=1 -> tready=0, m01 tvalid=0, occupancy=0.
//  2 Mode 0, m_ready=1: write 0x11,0x22,0x33,0x44 (tlast on 0x44) -> same order on m01, first
//    tvalid 2 cycles after first write, tlast only with 0x44, occupancy back to 0.
//  3 Mode 0, ADDR_WIDTH=4, m_ready=0: offer 20 beats 0..19 -> 16 accepted, tready=0, occupancy=16;
//    raise m_ready -> 0..15 out in order (wrap verified); beat 16 accepted when occupancy=15.
//  4 Mode 1: 3-beat packet A,B,C -> m01 tvalid stays 0 until 2 cycles after C accepted, pkt_count=1,
//    then A,B,C contiguous; stalling m_ready mid-packet holds tdata stable.
//  5 Mode 1, ADDR_WIDTH=4: 20-beat packet -> exactly one drop_pulse, all 20 accepted, nothing on m01,
//    occupancy=0; following 2-beat packet 0xAA,0xBB delivered intact.
//  6 Reset asserted after 5 beats of a 10-beat packet (mode 1) -> occupancy=0, pkt_count=0;
//    new 1-beat packet 0x5A then delivered with tlast=1.

Source files
------------

// File: rtl/axis_packet_buffer.sv
// AXI-Stream circular buffer with a first-word-fall-through output register and an
// optional store-and-forward mode that discards packets too large to ever fit.
module axis_packet_buffer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned PACKET_MODE = 0
) (
   input  logic                      axis_aclk,
   input  logic                      axis_areset,
   input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
   input  logic                      s01_axis_tvalid,
   input  logic                      s01_axis_tlast,
   output logic                      s01_axis_tready,
   output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
   output logic                      m01_axis_tvalid,
   output logic                      m01_axis_tlast,
   input  logic                      m01_axis_tready,
   output logic [ADDR_WIDTH:0]       occupancy,
   output logic [ADDR_WIDTH:0]       pkt_count,
   output logic                      drop_pulse
);

   localparam int unsigned SW    = DATA_WIDTH / 8;
   localparam int unsigned WW    = DATA_WIDTH + SW + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   typedef enum logic {StAccept, StDiscard} wr_state_t;

   logic [WW-1:0]         r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_pkt_len;
   logic [ADDR_WIDTH:0]   r_commit;
   logic [ADDR_WIDTH:0]   r_avail;
   logic [ADDR_WIDTH:0]   r_occ;
   logic [ADDR_WIDTH:0]   r_pkt_cnt;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [SW-1:0]         r_out_strb;
   logic                  r_drop;
   wr_state_t             r_state;

   logic                  w_s_ready;
   logic                  w_wr_fire;
   logic                  w_wr_store;
   logic                  w_rd_fire;
   logic                  w_load;
   logic                  w_drop;
   logic [WW-1:0]         w_rd_word;
   logic [ADDR_WIDTH:0]   w_release;

   assign w_s_ready  = !axis_areset && ((r_state == StDiscard) || (r_occ < CNT_FULL));
   assign w_wr_fire  = s01_axis_tvalid && w_s_ready;
   assign w_wr_store = w_wr_fire && (r_state == StAccept);
   assign w_rd_fire  = r_out_valid && m01_axis_tready;
   // r_avail counts only words already made visible to the reader (one cycle after commit)
   assign w_load     = (r_avail != '0) && (!r_out_valid || m01_axis_tready);
   assign w_drop     = (PACKET_MODE != 0) && (r_state == StAccept) && (r_occ == CNT_FULL)
                       && (r_pkt_cnt == '0);
   assign w_rd_word  = r_mem[r_rd_ptr];
   assign w_release  = w_drop ? r_pkt_len : '0;

   always_ff @(posedge axis_aclk) begin
      if (w_wr_store) begin
         r_mem[r_wr_ptr] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_pkt_len   <= '0;
         r_commit    <= '0;
         r_avail     <= '0;
         r_occ       <= '0;
         r_pkt_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_out_strb  <= '0;
         r_drop      <= 1'b0;
         r_state     <= StAccept;
      end else begin
         r_drop    <= 1'b0;
         r_commit  <= '0;
         r_occ     <= r_occ + {{ADDR_WIDTH{1'b0}}, w_wr_store}
                      - {{ADDR_WIDTH{1'b0}}, w_rd_fire} - w_release;
         r_pkt_cnt <= r_pkt_cnt + {{ADDR_WIDTH{1'b0}}, w_wr_store && s01_axis_tlast}
                      - {{ADDR_WIDTH{1'b0}}, w_rd_fire && r_out_last};
         r_avail   <= r_avail + r_commit - {{ADDR_WIDTH{1'b0}}, w_load};

         if (w_load) begin
            {r_out_last, r_out_strb, r_out_data} <= w_rd_word;
            r_out_valid <= 1'b1;
            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
         end else if (w_rd_fire) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            StAccept: begin
               if (w_drop) begin
                  // whole RAM holds one unfinished packet: rewind over it and skip the rest
                  r_wr_ptr  <= r_wr_ptr - r_pkt_len[ADDR_WIDTH-1:0];
                  r_pkt_len <= '0;
                  r_drop    <= 1'b1;
                  r_state   <= StDiscard;
               end else if (w_wr_store) begin
                  r_wr_ptr <= r_wr_ptr + PTR_ONE;
                  if (PACKET_MODE == 0) begin
                     r_commit <= CNT_ONE;
                  end else if (s01_axis_tlast) begin
                     r_commit  <= r_pkt_len + CNT_ONE;
                     r_pkt_len <= '0;
                  end else begin
                     r_pkt_len <= r_pkt_len + CNT_ONE;
                  end
               end
            end
            StDiscard: begin
               if (w_wr_fire && s01_axis_tlast) begin
                  r_state <= StAccept;
               end
            end
            default: r_state <= StAccept;
         endcase
      end
   end

   assign s01_axis_tready = w_s_ready;
   assign m01_axis_tdata  = r_out_data;
   assign m01_axis_tstrb  = r_out_strb;
   assign m01_axis_tvalid = r_out_valid;
   assign m01_axis_tlast  = r_out_last;
   assign occupancy       = r_occ;
   assign pkt_count       = r_pkt_cnt;
   assign drop_pulse      = r_drop;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Bench for axis_packet_buffer: dut 0 is cut-through, dut 1 store-and-forward, both 16 deep.
// A queue model per dut is compared every cycle; directed tests add literal expectations.
`timescale 1ns/1ps
module tb_axis_packet_buffer;

   localparam int unsigned DW    = 16;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
      logic [31:0]   t;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]           rst;
   logic [1:0]           s_valid;
   logic [1:0]           s_last;
   logic [1:0]           m_ready;
   logic [1:0][DW-1:0]   s_data;
   logic [1:0][SW-1:0]   s_strb;
   logic [1:0]           s_ready;
   logic [1:0]           m_valid;
   logic [1:0]           m_last;
   logic [1:0]           drop;
   logic [1:0][DW-1:0]   m_data;
   logic [1:0][SW-1:0]   m_strb;
   logic [1:0][AW:0]     occ;
   logic [1:0][AW:0]     pkts;

   logic [DW:0] seen0[$];
   logic [DW:0] seen1[$];
   int drop_seen0 = 0;
   int drop_seen1 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
         end
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ent_t q[$];
      ent_t pend[$];
      bit   discard   = 1'b0;
      bit   exp_valid = 1'b0;
      bit   exp_drop  = 1'b0;
      int unsigned edge_n = 0;

      axis_packet_buffer #(
         .DATA_WIDTH (DW),
         .ADDR_WIDTH (AW),
         .PACKET_MODE(g)
      ) u_dut (
         .axis_aclk      (clk),
         .axis_areset    (rst[g]),
         .s01_axis_tdata (s_data[g]),
         .s01_axis_tstrb (s_strb[g]),
         .s01_axis_tvalid(s_valid[g]),
         .s01_axis_tlast (s_last[g]),
         .s01_axis_tready(s_ready[g]),
         .m01_axis_tdata (m_data[g]),
         .m01_axis_tstrb (m_strb[g]),
         .m01_axis_tvalid(m_valid[g]),
         .m01_axis_tlast (m_last[g]),
         .m01_axis_tready(m_ready[g]),
         .occupancy      (occ[g]),
         .pkt_count      (pkts[g]),
         .drop_pulse     (drop[g])
      );

      always @(posedge clk) begin
         int   pk;
         int   m_occ;
         bit   rd;
         bit   wr;
         ent_t e;
         edge_n++;
         if (!rst[g] && m_valid[g] && m_ready[g]) begin
            if (g == 0) seen0.push_back({m_last[g], m_data[g]});
            else        seen1.push_back({m_last[g], m_data[g]});
         end
         if (rst[g]) begin
            q.delete();
            pend.delete();
            discard   = 1'b0;
            exp_drop  = 1'b0;
            exp_valid = 1'b0;
         end else begin
            m_occ = q.size() + pend.size();
            pk = 0;
            foreach (q[i]) if (q[i].last) pk++;
            rd = exp_valid && m_ready[g];
            wr = s_valid[g] && (discard || m_occ < int'(DEPTH));
            exp_drop = 1'b0;
            if (g == 1 && !discard && m_occ == int'(DEPTH) && pk == 0) begin
               pend.delete();
               discard  = 1'b1;
               exp_drop = 1'b1;
            end
            if (rd) void'(q.pop_front());
            if (wr) begin
               e = '{data: s_data[g], strb: s_strb[g], last: s_last[g], t: edge_n};
               if (discard) begin
                  if (s_last[g]) discard = 1'b0;
               end else if (g == 0) begin
                  q.push_back(e);
               end else begin
                  pend.push_back(e);
                  if (s_last[g]) begin
                     foreach (pend[i]) begin
                        e   = pend[i];
                        e.t = edge_n;
                        q.push_back(e);
                     end
                     pend.delete();
                  end
               end
            end
            // a committed beat becomes visible two edges after its commit edge
            exp_valid = (q.size() != 0) && (q[0].t + 2 <= edge_n);
         end
         #1;
         m_occ = q.size() + pend.size();
         pk = 0;
         foreach (q[i]) if (q[i].last) pk++;
         check($sformatf("dut%0d tvalid", g), m_valid[g], exp_valid);
         check($sformatf("dut%0d tready", g), s_ready[g],
               !rst[g] && (discard || m_occ < int'(DEPTH)));
         check($sformatf("dut%0d occupancy", g), occ[g], m_occ);
         check($sformatf("dut%0d pkt_count", g), pkts[g], pk);
         check($sformatf("dut%0d drop_pulse", g), drop[g], exp_drop);
         if (exp_valid) begin
            check($sformatf("dut%0d tdata", g), m_data[g], q[0].data);
            check($sformatf("dut%0d tstrb", g), m_strb[g], q[0].strb);
            check($sformatf("dut%0d tlast", g), m_last[g], q[0].last);
         end
         if (drop[g]) begin
            if (g == 0) drop_seen0++;
            else        drop_seen1++;
         end
      end
   end

   task automatic send(input int d, input logic [DW-1:0] data, input bit last,
                       output logic [AW:0] occ_at);
      int n = 0;
      occ_at = '0;
      @(negedge clk);
      s_valid[d] = 1'b1;
      s_data[d]  = data;
      s_strb[d]  = SW'($urandom);
      s_last[d]  = last;
      forever begin
         @(posedge clk);
         if (s_ready[d]) begin
            occ_at = occ[d];
            break;
         end
         if (++n > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send timeout: dut%0d beat 0x%0h never accepted", d, data);
            break;
         end
      end
   endtask

   task automatic settle(input int cycles);
      @(negedge clk);
      s_valid = '0;
      s_last  = '0;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic reset_all();
      @(negedge clk);
      rst     = 2'b11;
      s_valid = '0;
      s_last  = '0;
      m_ready = '0;
      repeat (2) @(negedge clk);
      rst = 2'b00;
      seen0.delete();
      seen1.delete();
   endtask

   task automatic check_seen(input int d, input string name, input logic [DW:0] exp[$]);
      logic [DW:0] got[$];
      if (d == 0) got = seen0;
      else        got = seen1;
      check({name, " count"}, got.size(), exp.size());
      if (got.size() == exp.size()) begin
         foreach (exp[i]) check($sformatf("%s beat %0d", name, i), got[i], exp[i]);
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [AW:0] oa;
      logic [DW:0] exp_q[$];
      bit   [1:0]  acc;
      int          d0;

      rst     = 2'b11;
      s_valid = 2'b11;
      s_last  = '0;
      s_data  = '0;
      s_strb  = '1;
      m_ready = '0;

      // 1: reset held with valid offered
      repeat (3) begin
         @(posedge clk);
         #2;
         for (int d = 0; d < 2; d++) begin
            check($sformatf("t1 tready d%0d", d), s_ready[d], 0);
            check($sformatf("t1 tvalid d%0d", d), m_valid[d], 0);
            check($sformatf("t1 occupancy d%0d", d), occ[d], 0);
            check($sformatf("t1 tdata d%0d", d), m_data[d], 0);
         end
      end
      reset_all();

      // 2: cut-through ordering and two-edge latency
      m_ready[0] = 1'b1;
      send(0, 16'h0011, 1'b0, oa);
      #2 check("t2 tvalid after k", m_valid[0], 0);
      send(0, 16'h0022, 1'b0, oa);
      #2 check("t2 tvalid after k+1", m_valid[0], 0);
      send(0, 16'h0033, 1'b0, oa);
      #2 check("t2 tvalid after k+2", m_valid[0], 1);
      check("t2 first tdata", m_data[0], 16'h0011);
      send(0, 16'h0044, 1'b1, oa);
      settle(10);
      exp_q = {17'h00011, 17'h00022, 17'h00033, 17'h10044};
      check_seen(0, "t2 stream", exp_q);
      check("t2 occupancy drained", occ[0], 0);

      // 3: fill to DEPTH, refuse, then drain across the wrap
      reset_all();
      for (int i = 0; i < 16; i++) send(0, DW'(i), 1'b0, oa);
      @(negedge clk);
      s_valid[0] = 1'b1;
      s_data[0]  = 16'd16;
      s_last[0]  = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #2 check("t3 tready when full", s_ready[0], 0);
      end
      check("t3 occupancy full", occ[0], 16);
      @(negedge clk);
      m_ready[0] = 1'b1;
      send(0, 16'd16, 1'b0, oa);
      check("t3 occupancy at beat 16", oa, 15);
      send(0, 16'd17, 1'b0, oa);
      send(0, 16'd18, 1'b0, oa);
      send(0, 16'd19, 1'b1, oa);
      settle(30);
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back({(i == 19) ? 1'b1 : 1'b0, DW'(i)});
      check_seen(0, "t3 stream", exp_q);

      // 4: store-and-forward holds the packet until tlast
      reset_all();
      send(1, 16'h000A, 1'b0, oa);
      send(1, 16'h000B, 1'b0, oa);
      send(1, 16'h000C, 1'b1, oa);
      #2 check("t4 tvalid at t", m_valid[1], 0);
      @(negedge clk);
      s_valid[1] = 1'b0;
      @(posedge clk);
      #2 check("t4 tvalid at t+1", m_valid[1], 0);
      check("t4 pkt_count", pkts[1], 1);
      @(posedge clk);
      #2 check("t4 tvalid at t+2", m_valid[1], 1);
      check("t4 first tdata", m_data[1], 16'h000A);
      @(negedge clk) m_ready[1] = 1'b1;
      @(negedge clk) m_ready[1] = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #2 check("t4 stalled tdata", m_data[1], 16'h000B);
      end
      @(negedge clk) m_ready[1] = 1'b1;
      settle(5);
      exp_q = {17'h0000A, 17'h0000B, 17'h1000C};
      check_seen(1, "t4 stream", exp_q);
      check("t4 pkt_count drained", pkts[1], 0);

      // 5: oversized packet dropped, next packet intact
      reset_all();
      m_ready[1] = 1'b1;
      d0 = drop_seen1;
      for (int i = 0; i < 20; i++) send(1, DW'(16'h0100 + i), i == 19, oa);
      settle(10);
      check("t5 drop pulses", drop_seen1 - d0, 1);
      check("t5 occupancy", occ[1], 0);
      check("t5 nothing out", seen1.size(), 0);
      send(1, 16'h00AA, 1'b0, oa);
      send(1, 16'h00BB, 1'b1, oa);
      settle(10);
      exp_q = {17'h000AA, 17'h100BB};
      check_seen(1, "t5 stream", exp_q);

      // 6: reset mid-packet
      reset_all();
      m_ready[1] = 1'b1;
      for (int i = 0; i < 5; i++) send(1, DW'(16'h0200 + i), 1'b0, oa);
      @(negedge clk);
      s_valid[1] = 1'b0;
      rst[1]     = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      check("t6 occupancy", occ[1], 0);
      check("t6 pkt_count", pkts[1], 0);
      seen1.delete();
      send(1, 16'h005A, 1'b1, oa);
      settle(6);
      exp_q = {17'h1005A};
      check_seen(1, "t6 stream", exp_q);

      // randomised traffic on both duts, model checked every cycle
      reset_all();
      acc = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!s_valid[d] || acc[d]) begin
               s_valid[d] = ($urandom_range(0, 3) != 0);
               s_data[d]  = DW'($urandom);
               s_strb[d]  = SW'($urandom);
               s_last[d]  = ($urandom_range(0, (d == 0) ? 4 : 7) == 0);
            end
            m_ready[d] = ($urandom_range(0, 99) < (((c / 250) % 2 == 1) ? 30 : 90));
            rst[d]     = ($urandom_range(0, 599) == 0);
         end
         @(posedge clk);
         for (int d = 0; d < 2; d++) acc[d] = s_valid[d] && s_ready[d];
      end
      settle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
